moving_sum: RTL
===============

Name: moving_sum

Overview:
- Downstream consumer of the DEPTH-stage shift register.
- Maintains a running sliding-window sum and average over the last DEPTH accepted samples.
- Each cycle: new sample in, sample leaving the window (the shift register's output) out; tracks window fill and flags when the window is full.
- Feeds threshold/filter logic that needs windowed statistics without a DEPTH-input adder tree.

Parameters:
- BITWIDTH, 32, width of each sample (unsigned).
- DEPTH, 8, window length; must equal the upstream shift register DEPTH; power of two, >= 2.
- SUMWIDTH, BITWIDTH+$clog2(DEPTH), running-sum width (derived; do not override).
- CNTWIDTH, $clog2(DEPTH+1), fill-counter width (derived).

Ports:
- iClk  input  1  clock; all state updates on rising edge.
- iRst  input  1  synchronous active-high reset.
- iEn  input  1  sample-accept strobe; must be the same signal driving the shift register's iEn.
- iClr  input  1  synchronous window clear; must be the same signal driving the shift register's iClr.
- iData  input  BITWIDTH  newest sample (same value presented to the shift register's iData).
- iDataOld  input  BITWIDTH  shift register oData = sample accepted DEPTH accepts earlier.
- oSum  output  SUMWIDTH  registered sum of samples currently in the window.
- oAvg  output  BITWIDTH  oSum >> $clog2(DEPTH) (truncating).
- oCount  output  CNTWIDTH  number of valid samples in window, 0..DEPTH.
- oValid  output  1  high when window holds DEPTH samples (state STEADY).

Behaviour:
- One clock, synchronous active-high reset iRst. No asynchronous logic.
- Reset values: oSum=0, oAvg=0, oCount=0, oValid=0, state=EMPTY.
- States:
  - EMPTY: count 0.
  - FILL: 0 < count < DEPTH.
  - STEADY: count == DEPTH.
- Transitions:
  - EMPTY -> FILL on iEn.
  - FILL -> STEADY on iEn when count == DEPTH-1.
  - STEADY holds.
  - Any state -> EMPTY on iClr or iRst.
- Update on a rising edge with iEn=1, iClr=0:
  - EMPTY/FILL: sum <= sum + iData; count <= count+1. iDataOld ignored (treated as 0), so stale upstream contents cannot corrupt the fill.
  - STEADY: sum <= sum + iData - iDataOld; count unchanged.
- iEn=0: all state holds; iData and iDataOld ignored.
- Priority: iRst > iClr > iEn. Simultaneous iClr and iEn clears; the sample is dropped (matches shift register clear semantics).
- Latency: 1 cycle. The sample accepted at edge k is reflected in oSum/oAvg/oCount/oValid after edge k.
- oAvg is combinational from registered oSum (no extra latency). During FILL it still divides by DEPTH, i.e. it is biased low; consumers gate on oValid.
- Arithmetic is unsigned. SUMWIDTH guarantees no overflow: max sum = DEPTH*(2^BITWIDTH-1). The intermediate add-then-subtract uses SUMWIDTH+1 bits, then truncates to SUMWIDTH (result always fits).
- Reset or clear mid-fill or mid-steady: everything returns to EMPTY the next cycle. The fill restarts from 0 regardless of iDataOld.
- Alignment requirement: the upstream shift register advances only on iEn. With iEn held high, iDataOld at accept k equals iData at accept k-DEPTH.

Decomposition:
- Shared package moving_sum_pkg:
  - state enum typedef (EMPTY, FILL, STEADY).
  - function clog2 helpers for SUMWIDTH/CNTWIDTH.
- No sub-module. The shift register stays a separate instance at the parent level, wired in parallel on iEn/iClr/iData.
- The bench instantiates both blocks together.

Test Plan:
- Reset then fill: iRst=1 for 5 cycles, then iData=1,2,...,8 with iEn=1 -> oSum=1,3,6,...,36. oCount=1..8. oValid rises after the 8th accept. oAvg=36>>3=4.
- Steady slide: continue with iData=9,10 -> oSum=44, then 52 (adds 9, drops 1; adds 10, drops 2). oAvg=5, then 6. oValid stays 1.
- Enable gating: in STEADY hold iEn=0 for 10 cycles with random iData -> oSum, oCount and oValid unchanged.
- Clear with simultaneous accept: in STEADY assert iClr=1 and iEn=1 with iData=100 -> next cycle oSum=0, oCount=0, oValid=0. The sample 100 is not counted.
- Max-value saturation check: 8 accepts of iData=32'hFFFF_FFFF -> oSum=35'h7_FFFF_FFF8, oAvg=32'hFFFF_FFFF, no wrap. Then 8 accepts of 0 -> oSum=0.
- Random soak: 1000 cycles of random iData and random iEn (~70% high), with iClr pulses every ~200 cycles -> oSum matches a software windowed sum of the last min(count,8) accepts on every cycle.

Source files
------------

// File: rtl/moving_sum_pkg.sv
// Shared types and constant helpers for the sliding-window sum block.
package moving_sum_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FILL   = 2'd1,
    STEADY = 2'd2
  } state_t;

  // Constant-evaluable ceil(log2(n)), used to derive the sum/count widths.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/moving_sum.sv
// Running sum/average over the last DEPTH accepted samples, fed in parallel
// with an upstream DEPTH-stage shift register whose output is iDataOld.
module moving_sum
  import moving_sum_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 8,
  localparam int SUMWIDTH = BITWIDTH + clog2(DEPTH),
  localparam int CNTWIDTH = clog2(DEPTH + 1)
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iClr,
  input  logic [BITWIDTH-1:0] iData,
  input  logic [BITWIDTH-1:0] iDataOld,
  output logic [SUMWIDTH-1:0] oSum,
  output logic [BITWIDTH-1:0] oAvg,
  output logic [CNTWIDTH-1:0] oCount,
  output logic                oValid
);

  localparam int LOG2D = clog2(DEPTH);
  localparam int SUMW1 = SUMWIDTH + 1;

  state_t              state, state_nxt;
  logic [SUMWIDTH-1:0] sum, sum_nxt;
  logic [CNTWIDTH-1:0] count, count_nxt;
  logic [SUMW1-1:0]    slide;

  // Extra bit keeps the add-then-subtract exact before truncation.
  assign slide = SUMW1'(sum) + SUMW1'(iData) - SUMW1'(iDataOld);

  always_comb begin
    state_nxt = state;
    sum_nxt   = sum;
    count_nxt = count;
    if (iClr) begin
      state_nxt = EMPTY;
      sum_nxt   = '0;
      count_nxt = '0;
    end else if (iEn) begin
      case (state)
        EMPTY, FILL: begin
          // iDataOld is stale while filling, so it is not subtracted.
          sum_nxt   = sum + SUMWIDTH'(iData);
          count_nxt = count + CNTWIDTH'(1);
          if (count == CNTWIDTH'(DEPTH - 1)) state_nxt = STEADY;
          else                               state_nxt = FILL;
        end
        STEADY: begin
          sum_nxt = slide[SUMWIDTH-1:0];
        end
        default: begin
          state_nxt = EMPTY;
          sum_nxt   = '0;
          count_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= EMPTY;
      sum   <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      sum   <= sum_nxt;
      count <= count_nxt;
    end
  end

  assign oSum   = sum;
  assign oAvg   = sum[SUMWIDTH-1:LOG2D];
  assign oCount = count;
  assign oValid = (state == STEADY);

endmodule
